// File: rtl/fan_pwm_controller.sv
// Fan sequencer: kick-start, glitch-free duty PWM, windowed tach edge count, sticky stall fault.
// Build option: define FAN_MIN_DUTY_EN to lift a nonzero RUN duty below MIN_DUTY up to MIN_DUTY.
module fan_pwm_controller #(
  parameter int PWM_DIV       = 8,
  parameter int TACH_WINDOW   = 50000000,
  parameter int KICK_CYCLES   = 25000000,
  parameter int STALL_WINDOWS = 2,
  parameter int MIN_DUTY      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cfg_duty,
  input  logic        cfg_enable,
  input  logic        cfg_valid,
  input  logic        tach_in,
  output logic        pwm_out,
  output logic [15:0] tach_count,
  output logic        tach_valid,
  output logic        stall,
  output logic [1:0]  state
);
  localparam int PS_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int WIN_W  = (TACH_WINDOW > 1) ? $clog2(TACH_WINDOW) : 1;
  localparam int KICK_W = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
  localparam int ZERO_W = $clog2(STALL_WINDOWS + 1);
  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(PWM_DIV - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(TACH_WINDOW - 1);
  localparam logic [KICK_W-1:0] KICK_LAST = KICK_W'(KICK_CYCLES - 1);
  localparam logic [ZERO_W-1:0] ZERO_LAST = ZERO_W'(STALL_WINDOWS - 1);
  localparam logic [7:0]        MIN_D     = 8'(MIN_DUTY);
`ifdef FAN_MIN_DUTY_EN
  localparam bit MIN_EN = 1'b1;
`else
  localparam bit MIN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_KICK = 2'd1, ST_RUN = 2'd2, ST_STALL = 2'd3} state_t;

  state_t            st_q, st_d;
  logic [7:0]        duty_req, duty_active, duty_eff, phase;
  logic              en_req;
  logic [PS_W-1:0]   ps_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [KICK_W-1:0] kick_cnt;
  logic [ZERO_W-1:0] zero_cnt;
  logic [15:0]       edge_cnt;
  logic [2:0]        tach_pipe;
  logic              ps_wrap, win_end, tach_rise, run_req, stall_hit, pwm_d;

  assign ps_wrap   = (ps_cnt == PS_LAST);
  assign win_end   = (win_cnt == WIN_LAST);
  assign tach_rise = tach_pipe[1] & ~tach_pipe[2];
  assign run_req   = en_req && (duty_req != 8'd0);
  assign stall_hit = win_end && (edge_cnt == 16'd0) && (zero_cnt == ZERO_LAST);
  assign duty_eff  = (MIN_EN && duty_active != 8'd0 && duty_active < MIN_D) ? MIN_D : duty_active;
  assign state     = st_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_req <= '0;
      en_req   <= 1'b0;
    end else if (cfg_valid) begin
      duty_req <= cfg_duty;
      en_req   <= cfg_enable;
    end
  end

  // Free-running PWM timebase; duty only changes at a period boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt      <= '0;
      phase       <= '0;
      duty_active <= '0;
    end else begin
      ps_cnt <= ps_wrap ? '0 : ps_cnt + 1'b1;
      if (ps_wrap) begin
        phase <= phase + 8'd1;
        if (phase == 8'hFF) duty_active <= duty_req;
      end
    end
  end

  // tach_pipe[1:0] is the synchronizer, tach_pipe[2] the previous synced level.
  always_ff @(posedge clk) begin
    if (reset) begin
      tach_pipe  <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      tach_count <= '0;
      tach_valid <= 1'b0;
    end else begin
      tach_pipe <= {tach_pipe[1:0], tach_in};
      win_cnt   <= win_end ? '0 : win_cnt + 1'b1;
      if (win_end) begin
        tach_count <= edge_cnt;
        tach_valid <= 1'b1;
        edge_cnt   <= {15'd0, tach_rise};
      end else begin
        tach_valid <= 1'b0;
        if (tach_rise && edge_cnt != 16'hFFFF) edge_cnt <= edge_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    st_d  = st_q;
    pwm_d = 1'b0;
    case (st_q)
      ST_OFF:   if (run_req) st_d = ST_KICK;
      ST_KICK: begin
        pwm_d = 1'b1;
        if (!run_req) st_d = ST_OFF;
        else if (kick_cnt == KICK_LAST) st_d = ST_RUN;
      end
      ST_RUN: begin
        pwm_d = (phase < duty_eff);
        if (!run_req) st_d = ST_OFF;
        else if (stall_hit) st_d = ST_STALL;
      end
      default:  if (cfg_valid) st_d = (cfg_enable && cfg_duty != 8'd0) ? ST_KICK : ST_OFF;
    endcase
  end

  // Counters idle at zero outside their state, so entering KICK/RUN always starts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= ST_OFF;
      stall    <= 1'b0;
      pwm_out  <= 1'b0;
      kick_cnt <= '0;
      zero_cnt <= '0;
    end else begin
      st_q     <= st_d;
      stall    <= (st_d == ST_STALL);
      pwm_out  <= pwm_d;
      kick_cnt <= (st_q == ST_KICK) ? kick_cnt + 1'b1 : '0;
      if (st_q != ST_RUN)  zero_cnt <= '0;
      else if (win_end)    zero_cnt <= (edge_cnt == 16'd0) ? zero_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_fan_pwm_controller.sv
// Bench for fan_pwm_controller: duty table, directed kick/tach/stall/reset sequences, random run vs time-based model.
module tb_fan_pwm_controller;
  localparam int PWM_DIV = 1, TACH_WINDOW = 1000, KICK_CYCLES = 512, STALL_WINDOWS = 2, MIN_DUTY = 64;
`ifdef FAN_MIN_DUTY_EN
  localparam int LOW_FLOOR = 64;
`else
  localparam int LOW_FLOOR = 0;
`endif
  localparam int EXP_D1  = (LOW_FLOOR > 1)  ? LOW_FLOOR : 1;
  localparam int EXP_D10 = (LOW_FLOOR > 10) ? LOW_FLOOR : 10;

  logic        clk = 1'b0, reset, cfg_enable, cfg_valid, tach_in;
  logic [7:0]  cfg_duty;
  logic        pwm_out, tach_valid, stall;
  logic [15:0] tach_count;
  logic [1:0]  state;
  int n_cmp = 0, n_bad = 0;
  int tach_mode = 0, tcnt = 0;

  // reference model state (time-indexed: phase and window position derive from m_k)
  int          m_k, m_win_edges, m_kick_t0, m_zero;
  logic [7:0]  m_req_duty, m_act_duty;
  logic        m_req_en, m_stall, m_pwm, m_tvalid;
  logic [1:0]  m_state;
  logic [15:0] m_tcount;
  logic [2:0]  m_hist;

  typedef struct { logic [7:0] duty; logic en; int exp_high; logic [1:0] exp_state; } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  fan_pwm_controller #(.PWM_DIV(PWM_DIV), .TACH_WINDOW(TACH_WINDOW), .KICK_CYCLES(KICK_CYCLES),
                       .STALL_WINDOWS(STALL_WINDOWS), .MIN_DUTY(MIN_DUTY)) dut (
    .clk(clk), .reset(reset), .cfg_duty(cfg_duty), .cfg_enable(cfg_enable), .cfg_valid(cfg_valid),
    .tach_in(tach_in), .pwm_out(pwm_out), .tach_count(tach_count), .tach_valid(tach_valid),
    .stall(stall), .state(state));

  function automatic logic [7:0] eff_duty(input logic [7:0] d);
    if (d != 8'd0 && int'(d) < LOW_FLOOR) return 8'(LOW_FLOOR);
    return d;
  endfunction

  task automatic model_step();
    logic [7:0] ph;
    logic rise, run_req, win_done;
    logic [1:0] nst;
    if (reset) begin
      m_k = 0; m_win_edges = 0; m_kick_t0 = 0; m_zero = 0; m_req_duty = 0; m_act_duty = 0;
      m_req_en = 0; m_stall = 0; m_pwm = 0; m_tvalid = 0; m_state = 0; m_tcount = 0; m_hist = 3'b000;
      return;
    end
    ph       = 8'((m_k / PWM_DIV) % 256);
    win_done = (m_k % TACH_WINDOW) == TACH_WINDOW - 1;
    rise     = m_hist[1] & ~m_hist[2];   // tach_in level sampled two and three edges back
    m_hist   = {m_hist[1:0], tach_in};
    m_pwm    = (m_state == 2'd1) || (m_state == 2'd2 && ph < eff_duty(m_act_duty));
    if ((m_k % PWM_DIV) == PWM_DIV - 1 && ph == 8'd255) m_act_duty = m_req_duty;
    run_req = m_req_en && m_req_duty != 8'd0;
    nst = m_state;
    case (m_state)
      2'd0: if (run_req) nst = 2'd1;
      2'd1: if (!run_req) nst = 2'd0; else if (m_k - m_kick_t0 + 1 == KICK_CYCLES) nst = 2'd2;
      2'd2: if (!run_req) nst = 2'd0;
            else if (win_done && m_win_edges == 0 && m_zero + 1 == STALL_WINDOWS) nst = 2'd3;
      default: if (cfg_valid) nst = (cfg_enable && cfg_duty != 8'd0) ? 2'd1 : 2'd0;
    endcase
    if (m_state == 2'd2 && win_done) m_zero = (m_win_edges == 0) ? m_zero + 1 : 0;
    if (nst == 2'd2 && m_state != 2'd2) m_zero = 0;
    if (nst == 2'd1 && m_state != 2'd1) m_kick_t0 = m_k + 1;
    if (win_done) begin
      m_tcount = 16'(m_win_edges); m_tvalid = 1'b1; m_win_edges = int'(rise);
    end else begin
      m_tvalid = 1'b0;
      if (m_win_edges < 65535) m_win_edges += int'(rise);
    end
    m_state = nst;
    m_stall = (nst == 2'd3);
    if (cfg_valid) begin m_req_duty = cfg_duty; m_req_en = cfg_enable; end
    m_k++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [20:0] act, exp;
    act = {pwm_out, tach_valid, stall, state, tach_count};
    exp = {m_pwm, m_tvalid, m_stall, m_state, m_tcount};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL model @%0t: got pwm=%0b tv=%0b stall=%0b state=%0d cnt=%0d expected pwm=%0b tv=%0b stall=%0b state=%0d cnt=%0d",
               $time, pwm_out, tach_valid, stall, state, tach_count, m_pwm, m_tvalid, m_stall, m_state, m_tcount);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    tcnt++;
    if (tach_mode == 1) tach_in = (tcnt % 25) < 12;
    else if (tach_mode == 2 && $urandom_range(0, 9) == 0) tach_in = ~tach_in;
    check_model();
  endtask

  task automatic write_cfg(input logic [7:0] d, input logic e);
    cfg_duty = d; cfg_enable = e; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n = 0;
    while (state != s && n < budget) begin tick(); n++; end
    check(name, int'(state), int'(s));
  endtask

  initial begin
    int n, hi, lo, klen, khigh;
    vecs[0] = '{8'd128, 1'b1, 128,     2'd2};
    vecs[1] = '{8'd32,  1'b1, 32,      2'd2};
    vecs[2] = '{8'd255, 1'b1, 255,     2'd2};
    vecs[3] = '{8'd1,   1'b1, EXP_D1,  2'd2};
    vecs[4] = '{8'd10,  1'b1, EXP_D10, 2'd2};
    vecs[5] = '{8'd90,  1'b0, 0,       2'd0};
    vecs[6] = '{8'd200, 1'b1, 200,     2'd2};

    reset = 1'b1; cfg_duty = 8'd0; cfg_enable = 1'b0; cfg_valid = 1'b0; tach_in = 1'b0;
    tick(); tick();
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_tach_count", int'(tach_count), 0);
    check("rst_tach_valid", int'(tach_valid), 0);
    check("rst_stall", int'(stall), 0);
    check("rst_state", int'(state), 0);
    reset = 1'b0;
    tach_mode = 1;

    // kick: 512 cycles in KICK, pwm high throughout (one-cycle lag)
    write_cfg(8'd128, 1'b1);
    wait_state(2'd1, 10, "kick_enter");
    klen = 0; khigh = 0;
    while (state == 2'd1 && klen < 2000) begin
      klen++; khigh += int'(pwm_out);
      tick();
    end
    check("kick_len", klen, KICK_CYCLES);
    check("kick_pwm_high", khigh, KICK_CYCLES - 1);
    check("kick_pwm_tail", int'(pwm_out), 1);
    check("kick_to_run", int'(state), 2);

    // duty table: high cycles per 256-cycle period
    for (int i = 0; i < 7; i++) begin
      write_cfg(vecs[i].duty, vecs[i].en);
      repeat (600) tick();
      hi = 0;
      for (int j = 0; j < 256; j++) begin hi += int'(pwm_out); tick(); end
      check($sformatf("duty_high[%0d]", i), hi, vecs[i].exp_high);
      check($sformatf("duty_state[%0d]", i), int'(state), int'(vecs[i].exp_state));
    end

    // tach: 40 rising edges per window
    n = 0;
    while (!tach_valid && n < 1100) begin tick(); n++; end
    check("tach_valid_seen", int'(tach_valid), 1);
    tick();
    check("tach_valid_pulse", int'(tach_valid), 0);
    n = 1;
    while (!tach_valid && n < 1100) begin tick(); n++; end
    check("tach_period", n, TACH_WINDOW);
    check("tach_count", int'(tach_count), 40);
    check("tach_no_stall", int'(stall), 0);

    // mid-period duty change 128 -> 32
    write_cfg(8'd128, 1'b1);
    repeat (600) tick();
    n = 0; while (pwm_out && n < 300) begin tick(); n++; end
    n = 0; while (!pwm_out && n < 300) begin tick(); n++; end
    hi = 0;
    while (pwm_out && hi < 400) begin
      hi++;
      cfg_valid = (hi == 50);
      cfg_duty = 8'd32; cfg_enable = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    check("period_old_high", hi, 128);
    lo = 0; while (!pwm_out && lo < 400) begin lo++; tick(); end
    check("period_old_low", lo, 128);
    hi = 0; while (pwm_out && hi < 400) begin hi++; tick(); end
    check("period_new_high", hi, 32);
    write_cfg(8'd0, 1'b1);
    tick(); tick();
    check("duty0_state", int'(state), 0);
    check("duty0_pwm", int'(pwm_out), 0);

    // reset during KICK
    write_cfg(8'd150, 1'b1);
    wait_state(2'd1, 10, "kick2_enter");
    repeat (30) tick();
    reset = 1'b1;
    tick();
    check("rstkick_pwm", int'(pwm_out), 0);
    check("rstkick_state", int'(state), 0);
    check("rstkick_tach_count", int'(tach_count), 0);
    check("rstkick_stall", int'(stall), 0);
    check("rstkick_tach_valid", int'(tach_valid), 0);
    reset = 1'b0;

    // stall after two zero-edge windows, then recovery via cfg write
    write_cfg(8'd128, 1'b1);
    wait_state(2'd2, 700, "stall_pre_run");
    tach_mode = 0; tach_in = 1'b0;
    n = 0;
    while (!stall && n < 4000) begin tick(); n++; end
    check("stall_set", int'(stall), 1);
    check("stall_state", int'(state), 3);
    check("stall_delay_in_range", int'(n >= 1975 && n <= 3010), 1);
    tick();
    check("stall_pwm", int'(pwm_out), 0);
    write_cfg(8'd100, 1'b1);
    check("stall_clear", int'(stall), 0);
    check("stall_rekick", int'(state), 1);

    // randomized traffic against the model
    tach_mode = 1;
    for (int i = 0; i < 12000; i++) begin
      cfg_valid = ($urandom_range(0, 199) == 0);
      if (cfg_valid) begin
        cfg_duty   = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        cfg_enable = ($urandom_range(0, 3) != 0);
      end
      reset = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 1499) == 0) tach_mode = $urandom_range(0, 2);
      tick();
    end
    cfg_valid = 1'b0; reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fan_pwm_controller.md
Name: fan_pwm_controller

Overview:
- Closed-loop sequencer for the board fan, sitting between the fan_control PIO and the fan header.
- Generates the fan PWM from a host-written duty and soft-starts the fan with a full-power kick.
- Measures tachometer edges per fixed window and latches a sticky stall fault when the fan stops turning.
- Status outputs feed back to the host through an input PIO.

Parameters:
- PWM_DIV, 8: clock cycles per PWM phase step; PWM period = PWM_DIV*256 cycles.
- TACH_WINDOW, 50000000: tach measurement window length in clk cycles.
- KICK_CYCLES, 25000000: length of the 100% duty kick on start.
- STALL_WINDOWS, 2: consecutive zero-edge windows in RUN that declare a stall.
- MIN_DUTY, 64: duty floor; used only with FAN_MIN_DUTY_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_duty  in  8  requested duty, 0..255
- cfg_enable  in  1  fan enable
- cfg_valid  in  1  one-cycle strobe; latches cfg_duty/cfg_enable and clears stall
- tach_in  in  1  raw asynchronous tachometer input
- pwm_out  out  1  PWM drive to fan
- tach_count  out  16  edges counted in last completed window
- tach_valid  out  1  one-cycle pulse when tach_count updates
- stall  out  1  sticky stall fault
- state  out  2  0=OFF 1=KICK 2=RUN 3=STALL

Behaviour:
- Reset values (synchronous, active-high, applied on the clk edge):
  - pwm_out=0, tach_count=0, tach_valid=0, stall=0, state=OFF.
  - Latched duty=0, latched enable=0; all counters cleared.
- Reset asserted mid-operation aborts KICK/RUN immediately. pwm_out is 0 on the cycle after the reset edge.
- Config register:
  - cfg_valid latches duty_req and en_req.
  - cfg_duty/cfg_enable are ignored without cfg_valid.
- PWM generation:
  - Prescaler counts 0..PWM_DIV-1; the 8-bit phase counter increments on prescaler wrap and wraps 255->0.
  - duty_active loads from duty_req only when phase wraps to 0, so there are no glitched periods.
  - In RUN: pwm_out = (phase < duty_active). Duty 0 gives constant low; duty 255 gives 255/256 high.
  - Prescaler and phase free-run in all states.
- Tach measurement:
  - tach_in passes through a 2-FF synchronizer, then a rising-edge detect.
  - The window counter runs 0..TACH_WINDOW-1 in all states.
  - The edge counter saturates at 0xFFFF.
  - At the window end: tach_count <= edges, tach_valid=1 for one cycle, edge counter reloads (1 if an edge coincides, else 0).
- FSM:
  - OFF: pwm_out=0. If en_req=1 and duty_req!=0, go to KICK and clear the kick counter.
  - KICK: pwm_out=1 for KICK_CYCLES cycles, then RUN. If en_req=0 or duty_req=0, go to OFF.
  - RUN: PWM as above. If en_req=0 or duty_req=0, go to OFF. Otherwise, if STALL_WINDOWS consecutive completed windows report 0 edges, go to STALL and set stall=1.
  - STALL: pwm_out=0; stall stays 1.
    - cfg_valid with cfg_enable=1 and cfg_duty!=0: clear stall, go to KICK.
    - cfg_valid otherwise: clear stall, go to OFF.
- Zero-window counter:
  - Counts only windows ending while in RUN.
  - Clears on any nonzero window and on entry to RUN.
  - The first window ending in RUN counts in full.
- Priority (same cycle): reset > disable/zero duty > stall detection > kick completion.
- Simultaneous cfg_valid and window end: both take effect; the FSM uses the newly latched values from the next cycle.
- State transitions take effect on the clk edge; pwm_out is registered, so it follows state with 1-cycle latency.

Optional Feature:
- Macro: FAN_MIN_DUTY_EN.
- Defined: in RUN, a nonzero duty_active below MIN_DUTY is driven as MIN_DUTY. Duty 0 still means OFF.
- Undefined: duty is used unmodified and the MIN_DUTY parameter has no effect.

Test Plan:
Bench parameters for all scenarios: PWM_DIV=1, TACH_WINDOW=1000, KICK_CYCLES=512, STALL_WINDOWS=2.
- Reset; write duty=128, enable=1 -> state=KICK, pwm_out high for 512 cycles; then RUN with 128 high / 128 low per 256-cycle period.
- In RUN, toggle tach_in with 40 rising edges per window -> tach_valid pulses every 1000 cycles, tach_count=40, stall=0.
- In RUN, hold tach_in static -> after the 2nd completed zero-edge window: stall=1, state=3, pwm_out=0. Then write enable=1, duty=100 -> stall=0, KICK.
- Change duty 128->32 mid-period -> current period completes at 128; the next period starts with 32 high cycles. Then write duty=0 -> state=OFF, pwm_out=0.
- Assert reset during KICK -> next cycle: pwm_out=0, state=OFF, tach_count=0, stall=0.
- With FAN_MIN_DUTY_EN, duty=10 -> 64 high cycles per period. Without it -> 10 high cycles.
